// File: rtl/dice_roll_capture_if.sv
// rtl/dice_roll_capture_if.sv - result handshake between dice capture and its consumer
interface dice_roll_capture_if;
    logic [2:0] result;
    logic       result_valid;
    logic       result_ready;

    modport master (
        output result,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  result,
        input  result_valid,
        output result_ready
    );
endinterface

// File: rtl/dice_roll_capture.sv
// rtl/dice_roll_capture.sv - captures the settled dice face after each roll, keeps stats and drives 7-seg
module dice_roll_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8,
    parameter int SUM_W         = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      button,
    input  logic [2:0]                throw,
    dice_roll_capture_if.master       res,
    output logic [CNT_W-1:0]          roll_count,
    output logic [SUM_W-1:0]          total,
    output logic [6:0]                seg,
    output logic                      bad_face,
    output logic                      overrun
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [2:0]      throw_q;
    logic            capture;

    logic [2:0]      result_q;
    logic            valid_q;
    logic [CNT_W-1:0] count_q;
    logic [SUM_W-1:0] total_q;
    logic [6:0]      seg_q;
    logic            bad_q;
    logic            ovr_q;

    logic [2:0]      face;
    logic            face_bad;
    logic            load;

    function automatic logic [6:0] seg_code(input logic [2:0] f);
        case (f)
            3'd1:    seg_code = 7'b0000110;
            3'd2:    seg_code = 7'b1011011;
            3'd3:    seg_code = 7'b1001111;
            3'd4:    seg_code = 7'b1100110;
            3'd5:    seg_code = 7'b1101101;
            3'd6:    seg_code = 7'b1111101;
            default: seg_code = 7'b0000000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            throw_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            throw_q <= throw;
        end
    end

    // Settle counter only advances while throw matches the previous sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (button) state_d = ROLLING;
            end
            ROLLING: begin
                if (!button) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (button) begin
                    state_d = ROLLING;
                    cnt_d   = '0;
                end else if (throw != throw_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                state_d = IDLE;
                capture = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign face_bad = (throw == 3'd0) || (throw == 3'd7);
    assign face     = face_bad ? 3'd1 : throw;
    assign load     = capture && (!valid_q || res.result_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            total_q  <= '0;
            seg_q    <= '0;
            bad_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (capture && face_bad) bad_q <= 1'b1;
            if (capture && !load)    ovr_q <= 1'b1;
            if (load) begin
                result_q <= face;
                valid_q  <= 1'b1;
                seg_q    <= seg_code(face);
                total_q  <= total_q + SUM_W'(face);
                if (count_q != {CNT_W{1'b1}}) count_q <= count_q + 1'b1;
            end else if (valid_q && res.result_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign res.result       = result_q;
    assign res.result_valid = valid_q;
    assign roll_count       = count_q;
    assign total            = total_q;
    assign seg              = seg_q;
    assign bad_face         = bad_q;
    assign overrun          = ovr_q;

endmodule
